// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle controller, immediate generator and ALU control.
package riscv_ctrl_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned OPCODE_W = 7;

  // Supported base opcodes
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_OPIMM  = 3'd3,
    CLS_OP     = 3'd4,
    CLS_BRANCH = 3'd5
  } op_class_t;

  // Static per-opcode control bundle produced by ctrl_decode
  typedef struct packed {
    op_class_t cls;
    logic      legal;
    imm_sel_t  imm_sel;
    logic      alu_src;
    alu_op_t   alu_op;
    logic      mem_to_reg;
  } ctrl_dec_t;

  // True for instructions that take a MEM cycle
  function automatic logic is_mem_op(input op_class_t cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus per-instruction static controls.
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output ctrl_dec_t           o_dec
);

  // Opcode lookup; unsupported opcodes leave legal=0 and all controls at their neutral values
  always_comb begin
    o_dec            = '0;
    o_dec.cls        = CLS_NONE;
    o_dec.imm_sel    = IMM_I;
    o_dec.alu_op     = ALU_ADD;
    case (i_opcode)
      OPC_LOAD: begin
        o_dec.cls        = CLS_LOAD;
        o_dec.legal      = 1'b1;
        o_dec.imm_sel    = IMM_I;
        o_dec.alu_src    = 1'b1;
        o_dec.alu_op     = ALU_ADD;
        o_dec.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        o_dec.cls     = CLS_STORE;
        o_dec.legal   = 1'b1;
        o_dec.imm_sel = IMM_S;
        o_dec.alu_src = 1'b1;
        o_dec.alu_op  = ALU_ADD;
      end
      OPC_OPIMM: begin
        o_dec.cls     = CLS_OPIMM;
        o_dec.legal   = 1'b1;
        o_dec.imm_sel = IMM_I;
        o_dec.alu_src = 1'b1;
        o_dec.alu_op  = ALU_FUNCT;
      end
      OPC_OP: begin
        o_dec.cls     = CLS_OP;
        o_dec.legal   = 1'b1;
        o_dec.alu_src = 1'b0;
        o_dec.alu_op  = ALU_FUNCT;
      end
      OPC_BRANCH: begin
        o_dec.cls     = CLS_BRANCH;
        o_dec.legal   = 1'b1;
        o_dec.imm_sel = IMM_B;
        o_dec.alu_src = 1'b0;
        o_dec.alu_op  = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing plus retired-instruction counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst_code,
  input  logic              mem_ready,
  input  logic              alu_zero,
  output logic              mem_req,
  output logic              mem_we,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_branch,
  output logic              reg_write,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic [1:0]        imm_sel,
  output logic [1:0]        alu_op,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;
  ctrl_dec_t        w_dec;
  logic             w_unused_inst;

  // Only the opcode field steers the controller; funct/register fields go to the datapath
  assign w_unused_inst = ^inst_code[INST_W-1:OPCODE_W];

  ctrl_decode u_decode (
    .i_opcode (inst_code[OPCODE_W-1:0]),
    .o_dec    (w_dec)
  );

  // State register with synchronous reset; reset abandons any in-flight memory request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Retired counter: bumps on every instruction-completing transition into FETCH, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign retired = r_retired;

  // Next-state and control decode; everything stays quiet while reset is held
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_branch    = 1'b0;
    reg_write    = 1'b0;
    alu_src      = 1'b0;
    mem_to_reg   = 1'b0;
    imm_sel      = IMM_I;
    alu_op       = ALU_ADD;
    illegal      = 1'b0;

    if (!reset) begin
      // Static controls follow the instruction register from DECODE until it completes
      if ((r_state == ST_DECODE) || (r_state == ST_EXEC) ||
          (r_state == ST_MEM)    || (r_state == ST_WB)) begin
        imm_sel    = w_dec.imm_sel;
        alu_src    = w_dec.alu_src;
        alu_op     = w_dec.alu_op;
        mem_to_reg = w_dec.mem_to_reg;
      end

      case (r_state)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            w_next_state = ST_DECODE;
          end
        end
        ST_DECODE: begin
          w_next_state = w_dec.legal ? ST_EXEC : ST_HALT;
        end
        ST_EXEC: begin
          case (w_dec.cls)
            CLS_LOAD, CLS_STORE: w_next_state = ST_MEM;
            CLS_OPIMM, CLS_OP:   w_next_state = ST_WB;
            CLS_BRANCH: begin
              pc_branch    = alu_zero;
              w_retire     = 1'b1;
              w_next_state = ST_FETCH;
            end
            default:             w_next_state = ST_HALT;
          endcase
        end
        ST_MEM: begin
          mem_req = is_mem_op(w_dec.cls);
          mem_we  = (w_dec.cls == CLS_STORE);
          if (mem_ready) begin
            if (w_dec.cls == CLS_STORE) begin
              w_retire     = 1'b1;
              w_next_state = ST_FETCH;
            end else begin
              w_next_state = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_write    = 1'b1;
          w_retire     = 1'b1;
          w_next_state = ST_FETCH;
        end
        ST_HALT: begin
          illegal = 1'b1;
        end
        default: begin
          w_next_state = ST_HALT;
        end
      endcase
    end
  end

endmodule
